binary_decoder_scan: RTL
========================

Name: binary_decoder_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder.
- Direct mode: decodes `in`, like the existing combinational decoders, with one cycle of latency.
- Scan mode: autonomously sequences one-hot through every output, holding each for a programmable dwell time. Intended for digit or row multiplexing of displays and LED matrices.
- Used wherever a decoder output must be glitch-free and registered.

Parameters:
- IN_W, 3, width of the binary index. OUT_W = 2**IN_W is a derived localparam, not overridable.
- DWELL, 4, clock cycles each output stays active in scan mode. Must be >= 1.
- ACTIVE_LOW, 0, 1 = outputs are active-low: the active bit is 0 and all others are 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- en  input  1  global enable. 0 forces all outputs inactive.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- in  input  IN_W  index to decode (direct) or scan start index (on entry/load).
- load  input  1  scan mode only: restart the scan at `in`.
- out  output  OUT_W  registered one-hot (or one-cold) decode.
- sel  output  IN_W  index currently driven on `out`.
- wrap  output  1  one-cycle pulse when the scan index wraps from OUT_W-1 to 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=OFF, sel=0, dwell counter=0, wrap=0.
  - out = all inactive: all 0s, or all 1s if ACTIVE_LOW.
- All registers update on the rising edge of clk. `out` always equals decode(sel) when active, so out and sel are consistent in the same cycle.
- States: OFF, DIRECT, SCAN. The next state is evaluated every cycle:
  - en=0 -> OFF.
  - en=1 and mode=0 -> DIRECT.
  - en=1 and mode=1 -> SCAN.
- OFF:
  - out all inactive, wrap=0.
  - sel and dwell counter hold their values.
- DIRECT:
  - sel <= in; out <= decode(in).
  - Latency is 1 cycle from `in` to `out`.
  - Dwell counter is cleared. `load` is ignored.
- Entering SCAN from OFF or DIRECT:
  - sel <= in, dwell counter <= 0, out <= decode(in), wrap=0.
- In SCAN:
  - Dwell counter increments each cycle.
  - When the counter reaches DWELL-1, it returns to 0 and sel advances by 1 on the same edge.
  - Each index is therefore active for exactly DWELL cycles.
- Wrap-around:
  - Advancing from sel=OUT_W-1 gives sel=0, and wrap=1 for exactly that one cycle, aligned with out=decode(0).
- load=1 in SCAN:
  - sel <= in, dwell counter <= 0.
  - Load takes priority over a simultaneous dwell terminal advance. No wrap pulse is generated on load, even if in=0.
- DWELL=1: sel advances every cycle.
- Mode change SCAN->DIRECT: takes effect on the next edge; the scan position is discarded.
- en deasserted mid-scan: out goes inactive on the next edge; sel is frozen.
  - Re-enabling in scan counts as entry to SCAN and reloads from `in`.
- Reset mid-scan: all outputs return immediately (asynchronously) to their reset values.
- Dwell counter width: $clog2(DWELL), minimum 1 bit. Counters must never take values >= DWELL.

Optional Feature:
- Macro: BINARY_DECODER_SCAN_SKIP_EN.
- When defined:
  - Adds input port skip_mask, width OUT_W. In SCAN, advancing selects the next index above sel, circularly, whose skip_mask bit is 0.
  - wrap pulses when the advance passes through index OUT_W-1 to a lower index.
  - If all bits are masked, out is inactive and sel holds.
  - A load to a masked index is accepted; that index is then shown for one dwell period.
  - DIRECT mode ignores the mask.
- When undefined: no skip_mask port, and all indices are scanned.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> out=8'h00, sel=0, wrap=0 immediately, without waiting for a clock edge.
- Direct mode, IN_W=3: en=1, mode=0, in=5 -> after 1 edge out=8'b0010_0000, sel=5. Then in=0 -> next edge out=8'h01.
- Scan mode, DWELL=4, in=6 at entry -> out=8'h40 for 4 cycles, 8'h80 for 4 cycles, then 8'h01 with wrap=1 for 1 cycle only.
- load=1 with in=2 on the cycle the dwell counter is at DWELL-1 -> next out=8'h04, no advance, no wrap, full 4-cycle dwell follows.
- en=0 for 3 cycles mid-scan at sel=3 -> out=8'h00, sel stays 3. en=1 again with in=1 -> out=8'h02 on the next edge. ACTIVE_LOW=1 run: same sequence, inverted out, reset out=8'hFF.
- With BINARY_DECODER_SCAN_SKIP_EN and skip_mask=8'b1010_1010, DWELL=1, start at 0 -> sel sequence 0,2,4,6,0 (wrap=1 on the return to 0). skip_mask=8'hFF -> out=8'h00, sel holds.

Source files
------------

// File: rtl/binary_decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a direct mode and an auto-scan mode.
// Optional skip mask for the scan sequence is enabled by defining BINARY_DECODER_SCAN_SKIP_EN.
module binary_decoder_scan #(
    parameter int IN_W       = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0,
    localparam int OUT_W     = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [IN_W-1:0]  in,
    input  logic             load,
`ifdef BINARY_DECODER_SCAN_SKIP_EN
    input  logic [OUT_W-1:0] skip_mask,
`endif
    output logic [OUT_W-1:0] out,
    output logic [IN_W-1:0]  sel,
    output logic             wrap
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{(ACTIVE_LOW != 0)}};

    typedef enum logic [1:0] {ST_OFF, ST_DIRECT, ST_SCAN} state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;

    logic [IN_W-1:0]  adv_idx;
    logic             adv_wrap;
    logic             all_masked;

    function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] idx);
        logic [OUT_W-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~onehot : onehot;
    endfunction

`ifdef BINARY_DECODER_SCAN_SKIP_EN
    logic [IN_W-1:0] cand;

    // Search downward so the nearest unmasked index above sel wins; k=OUT_W aliases sel itself.
    always_comb begin
        all_masked = &skip_mask;
        adv_idx    = sel_q;
        cand       = sel_q;
        for (int k = OUT_W; k >= 1; k--) begin
            cand = sel_q + IN_W'(k);
            if (!skip_mask[cand]) begin
                adv_idx = cand;
            end
        end
        adv_wrap = !all_masked && (adv_idx < sel_q);
    end
`else
    always_comb begin
        all_masked = 1'b0;
        adv_idx    = sel_q + IN_W'(1);
        adv_wrap   = (sel_q == IN_W'(OUT_W - 1));
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        out_d   = INACTIVE;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
        end else if (!mode) begin
            state_d = ST_DIRECT;
            sel_d   = in;
            cnt_d   = '0;
            out_d   = decode(in);
        end else begin
            state_d = ST_SCAN;
            // Entry and load both restart at `in`; load beats a terminal-count advance.
            if (state_q != ST_SCAN || load) begin
                sel_d = in;
                cnt_d = '0;
                out_d = decode(in);
            end else begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    sel_d  = adv_idx;
                    wrap_d = adv_wrap;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                out_d = all_masked ? INACTIVE : decode(sel_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            sel_q   <= '0;
            cnt_q   <= '0;
            out_q   <= INACTIVE;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

    assign out  = out_q;
    assign sel  = sel_q;
    assign wrap = wrap_q;

endmodule
